fixpt_sat_accumulator: RTL and testbench
========================================

// Module: fixpt_sat_accumulator
// PURPOSE
//   Parametrised, pipelined fixed-point add/sub/accumulate unit with valid/ready handshake.
//   Input is signed I_IN.Q_IN; output is signed I_OUT.Q_OUT, with round-half-up and saturation.
//   Next-generation arithmetic element for data_t-style datapaths (default 8.24 in).
//   Sits between a streaming source and a downstream consumer that can apply backpressure.
// PARAMETERS
//   I_IN      8   integer bits of inputs, sign bit included
//   Q_IN      24  fractional bits of inputs
//   I_OUT     8   integer bits of output, sign bit included
//   Q_OUT     16  fractional bits of output; must satisfy Q_OUT <= Q_IN, else elaboration $error
//   ACC_GUARD 4   extra MSBs in the accumulator (accumulator width W_ACC = I_IN+Q_IN+ACC_GUARD)
// PORTS
//   clk        in   1            system clock, rising edge
//   reset_n    in   1            asynchronous, active-low reset
//   in_valid   in   1            input beat valid
//   in_ready   out  1            input beat accepted when in_valid && in_ready
//   in_a       in   I_IN+Q_IN    operand A, signed, I_IN.Q_IN
//   in_b       in   I_IN+Q_IN    operand B, signed, I_IN.Q_IN
//   in_mode    in   2            00 ADD a+b; 01 SUB a-b; 10 ACC acc+a; 11 LOAD acc=a
//   in_last    in   1            final beat of an accumulation run
//   out_valid  out  1            result valid
//   out_ready  in   1            result consumed when out_valid && out_ready
//   out_data   out  I_OUT+Q_OUT  result, signed, I_OUT.Q_OUT
//   out_sat    out  1            result was clipped (accumulator, rounding or output range)
//   out_last   out  1            in_last of the originating beat
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - out_valid, out_data, out_sat, out_last = 0.
//     - Accumulator = 0; both pipeline stages empty.
//     - In-flight beats are discarded.
//   Pipeline and handshake:
//     - 2 stages: S1 = full-precision arithmetic; S2 = round, saturate, output register.
//     - advance = !S2_valid || out_ready. in_ready = advance (combinational; 1 after reset).
//     - Both stages move only on advance. Latency is 2 cycles, accepted beat to out_valid.
//     - Throughput 1 beat/clk while out_ready = 1.
//     - While out_valid && !out_ready: out_data, out_sat and out_last hold stable. No beat is lost or reordered.
//   S1 arithmetic:
//     - ADD/SUB computed at I_IN+Q_IN+1 bits; they never read or modify the accumulator.
//     - ACC: acc <= sat_W_ACC(acc + sext(a)); in_b is ignored.
//     - LOAD: acc <= sext(a).
//     - Accumulator overflow clips to the W_ACC max/min and sets the beat's sat flag.
//     - The S1 result for ACC/LOAD is the new accumulator value.
//     - Accepted beat with in_last = 1: the beat's result includes this beat, then acc <= 0.
//     - The accumulator updates only on accepted beats (in_valid && in_ready).
//   S2 conversion:
//     - D = Q_IN - Q_OUT. If D > 0: add 2^(D-1), then arithmetic shift right by D (round half toward +inf).
//     - Then clip to [-2^(I_OUT+Q_OUT-1), 2^(I_OUT+Q_OUT-1)-1].
//     - out_sat = S1 sat OR clip occurred (rounding carry into overflow counts as clip).
//   Simultaneous events: a new beat enters S1 in the same cycle S2 is consumed; both complete.
// TESTING (defaults; hex is raw two's complement)
//   1 ADD: a=0x01800000 (1.5), b=0x02400000 (2.25), out_ready=1 -> 2 clks later out_data=0x03C000, out_sat=0.
//   2 Saturation:
//     - ADD 0x7F000000 + 0x01000000 -> out_data=0x7FFFFF, out_sat=1.
//     - SUB 0x80000000 - 0x01000000 -> out_data=0x800000, out_sat=1.
//   3 Rounding, ADD with b=0:
//     - a=0x00000080 -> 0x000001.
//     - a=0x0000007F -> 0x000000.
//     - a=0xFFFFFF80 -> 0x000000.
//     - a=0xFFFFFF7F -> 0xFFFFFF.
//   4 Accumulate:
//     - LOAD 1.0, ACC 1.0, ACC 1.0, then ACC 1.0 with last -> 0x010000, 0x020000, 0x030000, 0x040000.
//     - out_last=1 only on the 4th result.
//     - A following ACC 1.0 -> 0x010000.
//   5 Backpressure:
//     - in_valid=1 with out_ready=0 for 5 clks -> exactly 2 beats accepted, in_ready=0 after that, out_data stable.
//     - Release out_ready -> all beats emerge in order, no duplicates.
//   6 Reset mid-run:
//     - Drop reset_n during an ACC run with out_valid=1 -> out_valid=0 with no clock edge.
//     - After release, ACC 1.0 -> 0x010000.

Source files
------------

// File: rtl/fixpt_sat_accumulator.sv
// Two-stage fixed-point add/sub/accumulate unit with a valid/ready handshake.
// S1 does full-precision arithmetic; S2 rounds half-up, saturates and holds the result.
module fixpt_sat_accumulator #(
  parameter int I_IN      = 8,
  parameter int Q_IN      = 24,
  parameter int I_OUT     = 8,
  parameter int Q_OUT     = 16,
  parameter int ACC_GUARD = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [I_IN+Q_IN-1:0]     in_a,
  input  logic [I_IN+Q_IN-1:0]     in_b,
  input  logic [1:0]               in_mode,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [I_OUT+Q_OUT-1:0]   out_data,
  output logic                     out_sat,
  output logic                     out_last
);

  localparam int W_IN  = I_IN + Q_IN;
  localparam int W_ACC = W_IN + ACC_GUARD;
  localparam int W_S1  = W_ACC + 1;
  localparam int W_R   = W_S1 + 1;
  localparam int W_OUT = I_OUT + Q_OUT;
  localparam int D     = Q_IN - Q_OUT;
  localparam logic [W_R-1:0] RND = (W_R'(1) << D) >> 1;

  if (Q_OUT > Q_IN) begin : g_bad_q
    $error("fixpt_sat_accumulator: Q_OUT must not exceed Q_IN");
  end

  typedef enum logic [1:0] {MODE_ADD, MODE_SUB, MODE_ACC, MODE_LOAD} mode_e;

  logic                    advance;
  logic signed [W_ACC-1:0] acc;
  logic signed [W_ACC-1:0] acc_next;
  logic signed [W_S1-1:0]  a_ext, b_ext, acc_sum, res;
  logic                    res_sat, acc_mode;

  logic                    s1_valid, s1_sat, s1_last;
  logic signed [W_S1-1:0]  s1_val;

  logic signed [W_R-1:0]   v_ext, r_sum, r_sh;
  logic [W_R-W_OUT:0]      r_top;
  logic                    out_fits;
  logic [W_OUT-1:0]        conv_data;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign a_ext   = {{(W_S1-W_IN){in_a[W_IN-1]}}, in_a};
  assign b_ext   = {{(W_S1-W_IN){in_b[W_IN-1]}}, in_b};
  assign acc_sum = {acc[W_ACC-1], acc} + a_ext;

  always_comb begin
    res      = '0;
    res_sat  = 1'b0;
    acc_next = acc;
    acc_mode = 1'b0;
    case (mode_e'(in_mode))
      MODE_ADD: res = a_ext + b_ext;
      MODE_SUB: res = a_ext - b_ext;
      MODE_ACC: begin
        acc_mode = 1'b1;
        // One spare MSB in acc_sum: overflow shows as disagreement of the top two bits
        if (acc_sum[W_S1-1] == acc_sum[W_ACC-1]) begin
          acc_next = acc_sum[W_ACC-1:0];
        end else begin
          res_sat  = 1'b1;
          acc_next = acc_sum[W_S1-1] ? {1'b1, {(W_ACC-1){1'b0}}}
                                     : {1'b0, {(W_ACC-1){1'b1}}};
        end
        res = {acc_next[W_ACC-1], acc_next};
      end
      MODE_LOAD: begin
        acc_mode = 1'b1;
        acc_next = a_ext[W_ACC-1:0];
        res      = a_ext;
      end
      default: res = '0;
    endcase
  end

  // Round half toward +inf, then clip; a rounding carry past the range is caught by the clip
  always_comb begin
    v_ext     = {s1_val[W_S1-1], s1_val};
    r_sum     = v_ext + RND;
    r_sh      = r_sum >>> D;
    r_top     = r_sh[W_R-1:W_OUT-1];
    out_fits  = (&r_top) || !(|r_top);
    conv_data = out_fits ? r_sh[W_OUT-1:0]
              : (r_sh[W_R-1] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      s1_valid  <= 1'b0;
      s1_val    <= '0;
      s1_sat    <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_last  <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_val  <= res;
        s1_sat  <= res_sat;
        s1_last <= in_last;
        if (acc_mode) begin
          acc <= in_last ? '0 : acc_next;
        end
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= conv_data;
        out_sat  <= s1_sat || !out_fits;
        out_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_fixpt_sat_accumulator.sv
// Bench for fixpt_sat_accumulator: directed literal cases plus randomized traffic
// checked every cycle against an integer reference model of the default 8.24 -> 8.16 unit.
module tb_fixpt_sat_accumulator;

  localparam longint ACC_MAX = (64'sd1 <<< 35) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< 35);
  localparam longint OUT_MAX = (64'sd1 <<< 23) - 1;
  localparam longint OUT_MIN = -(64'sd1 <<< 23);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_mode = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic        out_sat;
  logic        out_last;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] data;
    bit          sat;
    bit          last;
  } exp_t;

  exp_t   exp_q[$];
  longint model_acc = 0;

  fixpt_sat_accumulator dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic longint floor_div(input longint num, input longint den);
    return (num >= 0) ? num / den : -((-num + den - 1) / den);
  endfunction

  // Reference: exact integer arithmetic on the Q24 values, then round to Q16 and clamp
  function automatic exp_t model_beat(input logic [1:0] mode, input logic [31:0] a,
                                      input logic [31:0] b, input bit last);
    exp_t   e;
    longint av = longint'($signed(a));
    longint bv = longint'($signed(b));
    longint v  = 0;
    longint r;
    bit     sat = 1'b0;
    case (mode)
      2'd0: v = av + bv;
      2'd1: v = av - bv;
      2'd2: begin
        v = model_acc + av;
        if (v > ACC_MAX) begin v = ACC_MAX; sat = 1'b1; end
        if (v < ACC_MIN) begin v = ACC_MIN; sat = 1'b1; end
        model_acc = last ? 0 : v;
      end
      default: begin
        v = av;
        model_acc = last ? 0 : av;
      end
    endcase
    r = floor_div(v + 128, 256);
    if (r > OUT_MAX) begin r = OUT_MAX; sat = 1'b1; end
    if (r < OUT_MIN) begin r = OUT_MIN; sat = 1'b1; end
    e.data = r[23:0];
    e.sat  = sat;
    e.last = last;
    return e;
  endfunction

  // Scoreboard: outputs compared against the model queue every cycle, accepted beats enqueued
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      model_acc = 0;
    end else begin
      check_output("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0h required none", out_data);
        end else begin
          check_output("sb_data", 64'(out_data), 64'(exp_q[0].data));
          check_output("sb_sat", 64'(out_sat), 64'(exp_q[0].sat));
          check_output("sb_last", 64'(out_last), 64'(exp_q[0].last));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model_beat(in_mode, in_a, in_b, in_last));
    end
  end

  // One beat into an idle, unstalled pipeline; result must appear exactly two edges later
  task automatic apply_stimulus(input string name, input logic [1:0] mode, input logic [31:0] a,
                                input logic [31:0] b, input bit last,
                                input logic [23:0] exp_data, input bit exp_sat, input bit exp_last);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = mode;
    in_a      = a;
    in_b      = b;
    in_last   = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_output({name, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_output({name, "_valid"}, 64'(out_valid), 64'd1);
    check_output({name, "_data"}, 64'(out_data), 64'(exp_data));
    check_output({name, "_sat"}, 64'(out_sat), 64'(exp_sat));
    check_output({name, "_last"}, 64'(out_last), 64'(exp_last));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = 32'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000;
      1: v = $urandom();
      2: v = {8'h7F - 8'($urandom_range(0, 3)), 24'($urandom())};
      default: v = {24'($urandom()), ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F};
    endcase
    return v;
  endfunction

  initial begin
    int          accepted;
    bit          took;
    logic [23:0] held;

    #1;
    check_output("reset_valid", 64'(out_valid), 64'd0);
    check_output("reset_data", 64'(out_data), 64'd0);
    check_output("reset_sat", 64'(out_sat), 64'd0);
    check_output("reset_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    apply_stimulus("add", 2'd0, 32'h0180_0000, 32'h0240_0000, 1'b0, 24'h03C000, 1'b0, 1'b0);
    apply_stimulus("add_sat", 2'd0, 32'h7F00_0000, 32'h0100_0000, 1'b0, 24'h7FFFFF, 1'b1, 1'b0);
    apply_stimulus("sub_sat", 2'd1, 32'h8000_0000, 32'h0100_0000, 1'b0, 24'h800000, 1'b1, 1'b0);
    apply_stimulus("rnd_80", 2'd0, 32'h0000_0080, 32'h0, 1'b0, 24'h000001, 1'b0, 1'b0);
    apply_stimulus("rnd_7f", 2'd0, 32'h0000_007F, 32'h0, 1'b0, 24'h000000, 1'b0, 1'b0);
    apply_stimulus("rnd_m80", 2'd0, 32'hFFFF_FF80, 32'h0, 1'b0, 24'h000000, 1'b0, 1'b0);
    apply_stimulus("rnd_m81", 2'd0, 32'hFFFF_FF7F, 32'h0, 1'b0, 24'hFFFFFF, 1'b0, 1'b0);
    apply_stimulus("load", 2'd3, 32'h0100_0000, 32'hDEAD_BEEF, 1'b0, 24'h010000, 1'b0, 1'b0);
    apply_stimulus("acc2", 2'd2, 32'h0100_0000, 32'hDEAD_BEEF, 1'b0, 24'h020000, 1'b0, 1'b0);
    apply_stimulus("acc3", 2'd2, 32'h0100_0000, 32'hDEAD_BEEF, 1'b0, 24'h030000, 1'b0, 1'b0);
    apply_stimulus("acc4", 2'd2, 32'h0100_0000, 32'hDEAD_BEEF, 1'b1, 24'h040000, 1'b0, 1'b1);
    apply_stimulus("acc_new", 2'd2, 32'h0100_0000, 32'hDEAD_BEEF, 1'b0, 24'h010000, 1'b0, 1'b0);

    // Backpressure: the stalled pipeline must take exactly two beats and then freeze
    @(posedge clk); #1;
    out_ready = 1'b0;
    accepted  = 0;
    held      = '0;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_a      = rand_operand();
    in_b      = rand_operand();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) accepted++;
      if (i == 2) held = out_data;
      if (i == 4) check_output("bp_stable", 64'(out_data), 64'(held));
      @(posedge clk); #1;
      if (took) begin
        in_a = rand_operand();
        in_b = rand_operand();
      end
    end
    check_output("bp_accepted", 64'(accepted), 64'd2);
    check_output("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_output("bp_drained", 64'(exp_q.size()), 64'd0);

    // Randomized traffic with random backpressure; the scoreboard does the checking
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_mode  = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'($urandom_range(0, 3));
        in_a     = rand_operand();
        in_b     = rand_operand();
        in_last  = ($urandom_range(0, 15) == 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_output("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-run: outputs clear immediately, accumulator restarts from zero
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd3;
    in_a      = 32'h0100_0000;
    @(posedge clk); #1;
    in_mode = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("rst_pre_valid", 64'(out_valid), 64'd1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_output("rst_valid", 64'(out_valid), 64'd0);
    check_output("rst_data", 64'(out_data), 64'd0);
    check_output("rst_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    apply_stimulus("rst_acc", 2'd2, 32'h0100_0000, 32'h0, 1'b0, 24'h010000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
